// File: rtl/adc_frame_ctrl.sv
// Frame sequencer for a 12-bit serial ADC: timed cs/sclk frames, MSB-first capture, valid/ready out.
// Optional build macro TEST_PATTERN_EN adds test_mode, which substitutes a ramp for captured data.
module adc_frame_ctrl #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned QUIET_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
`ifdef TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        cs_adc,
  output logic        sclk_adc,
  input  logic        dout_adc,
  output logic [11:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);

  localparam logic [CW-1:0] DivLast    = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] PeriodLast = TW'(SAMPLE_PERIOD - 1);
  localparam logic [QW-1:0] QuietLast  = QW'(QUIET_CYCLES);
  localparam logic [QW-1:0] QuietMet   = QW'(QUIET_CYCLES - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StQuiet = 3'd4;

  if (SAMPLE_PERIOD < 32 * CLK_DIV + 1 + QUIET_CYCLES) begin : g_bad_period
    $error("adc_frame_ctrl: SAMPLE_PERIOD too short for CLK_DIV and QUIET_CYCLES");
  end
  if (CLK_DIV < 1 || QUIET_CYCLES < 1) begin : g_bad_div
    $error("adc_frame_ctrl: CLK_DIV and QUIET_CYCLES must be at least 1");
  end

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] div_q, div_d;
  logic [4:0]    half_q, half_d;
  logic [QW-1:0] hi_q, hi_d;
  logic [15:0]   shift_q, shift_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic [11:0]   sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          can_start, launch, load;
  logic [11:0]   new_sample;

`ifdef TEST_PATTERN_EN
  logic [11:0]   ramp_q, ramp_d;
  assign new_sample = test_mode ? ramp_q : shift_q[11:0];
`else
  assign new_sample = shift_q[11:0];
`endif

  // A new frame may also start straight out of DONE/QUIET once cs has been high long enough,
  // so the minimum legal SAMPLE_PERIOD still yields back-to-back frames.
  assign can_start = (state_q == StIdle) ||
                     (((state_q == StDone) || (state_q == StQuiet)) && (hi_q >= QuietMet));
  assign launch    = enable && (timer_q == '0) && can_start;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    hi_d      = hi_q;
    shift_d   = shift_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    load      = 1'b0;
`ifdef TEST_PATTERN_EN
    ramp_d    = ramp_q;
`endif

    if (!enable)                  timer_d = '0;
    else if (timer_q == PeriodLast) timer_d = '0;
    else                          timer_d = timer_q + TW'(1);

    unique case (state_q)
      StIdle: ;
      StSetup: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b0;
          state_d = StShift;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      StShift: begin
        // The 16th high phase lasts a single clk: the frame closes right after the last rise.
        if (half_q == 5'd31) begin
          load    = 1'b1;
          cs_d    = 1'b1;
          sclk_d  = 1'b1;
          div_d   = '0;
          hi_d    = '0;
          state_d = StDone;
        end else if (div_q == DivLast) begin
          div_d  = '0;
          half_d = half_q + 5'd1;
          sclk_d = ~sclk_q;
          if (!sclk_q) shift_d = (shift_q << 1) | 16'(dout_adc);
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      StDone: begin
        hi_d    = hi_q + QW'(1);
        state_d = StQuiet;
      end
      StQuiet: begin
        if (hi_q == QuietLast) begin
          hi_d    = '0;
          state_d = StIdle;
        end else begin
          hi_d = hi_q + QW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d = StSetup;
      cs_d    = 1'b0;
      sclk_d  = 1'b1;
      div_d   = '0;
      hi_d    = '0;
    end

    if (load) begin
      sample_d  = new_sample;
      valid_d   = 1'b1;
      overrun_d = valid_q && !sample_ready;
`ifdef TEST_PATTERN_EN
      if (test_mode) ramp_d = ramp_q + 12'd1;
`endif
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      div_q     <= '0;
      half_q    <= '0;
      hi_q      <= '0;
      shift_q   <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      half_q    <= half_d;
      hi_q      <= hi_d;
      shift_q   <= shift_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef TEST_PATTERN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ramp_q <= '0;
    else        ramp_q <= ramp_d;
  end
`endif

  assign cs_adc       = cs_q;
  assign sclk_adc     = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = ~cs_q;

endmodule

// File: tb/tb_adc_frame_ctrl.sv
// Directed bench for adc_frame_ctrl: CLK_DIV=2, SAMPLE_PERIOD=100, QUIET_CYCLES=2.
module tb_adc_frame_ctrl;

  localparam int RisePitch = 4;   // 2*CLK_DIV
  localparam int DoneLat   = 65;  // 32*CLK_DIV+1
  localparam int Period    = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        test_mode = 1'b0;
  logic        cs_adc, sclk_adc, sample_valid, overrun, busy;
  logic        dout_adc = 1'b0;
  logic        sample_ready = 1'b0;
  logic [11:0] sample;

  adc_frame_ctrl #(
    .CLK_DIV      (2),
    .SAMPLE_PERIOD(100),
    .QUIET_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
`ifdef TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .cs_adc      (cs_adc),
    .sclk_adc    (sclk_adc),
    .dout_adc    (dout_adc),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: next bit presented on each sclk fall, MSB first; index cleared when cs rises.
  logic [15:0] adc_word = 16'h0000;
  int bidx = 0;
  always @(negedge sclk_adc or posedge cs_adc) begin
    if (cs_adc) bidx = 0;
    else begin
      if (bidx < 16) dout_adc = adc_word[15 - bidx];
      bidx = bidx + 1;
    end
  end

  typedef struct {
    logic [15:0] word;
    logic        ready;
    logic [11:0] exp_sample;
    logic        exp_ovr;
  } vec_t;
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int t0, prev_t0, nrise, en_cyc;
  bit rise_ok, hold_ok;
  logic prev_sclk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_frame();
    int w = 0;
    while (cs_adc && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("frame_start_cs", int'(cs_adc), 0);
    t0 = cyc;
    nrise = 0;
    rise_ok = 1'b1;
    prev_sclk = sclk_adc;
  endtask

  // Step until cs_adc returns high or the cycle offset from T0 reaches stop_rel.
  task automatic run_to(input int stop_rel);
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (sclk_adc && !prev_sclk && !cs_adc) begin
        nrise++;
        if (cyc - t0 != RisePitch * nrise) rise_ok = 1'b0;
      end
      prev_sclk = sclk_adc;
      if (cs_adc || (cyc - t0 == stop_rel)) break;
    end
  endtask

  task automatic watch_idle(input int n, input bit want_valid);
    hold_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!cs_adc || sample_valid !== want_valid) hold_ok = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{16'h0AC3, 1'b1, 12'hAC3, 1'b0};
    vecs[1] = '{16'hF123, 1'b1, 12'h123, 1'b0};
    vecs[2] = '{16'h0FFF, 1'b0, 12'hFFF, 1'b0};
    vecs[3] = '{16'h5000, 1'b0, 12'h000, 1'b1};
    vecs[4] = '{16'hA555, 1'b0, 12'h555, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_cs", int'(cs_adc), 1);
    check("rst_sclk", int'(sclk_adc), 1);
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    watch_idle(5, 1'b0);
    check("disabled_idle", int'(hold_ok), 1);

    // Table-driven frames with continuous enable.
    enable = 1'b1;
    en_cyc = cyc;
    prev_t0 = 0;
    for (int i = 0; i < 5; i++) begin
      adc_word = vecs[i].word;
      sample_ready = vecs[i].ready;
      start_frame();
      check("busy_in_frame", int'(busy), 1);
      if (i == 0) check("first_start_lat", t0 - en_cyc, 1);
      else check("frame_period", t0 - prev_t0, Period);
      prev_t0 = t0;
      run_to(-1);
      check("done_lat", cyc - t0, DoneLat);
      check("rise_count", nrise, 16);
      check("rise_timing", int'(rise_ok), 1);
      check("done_sclk", int'(sclk_adc), 1);
      check("sample", int'(sample), int'(vecs[i].exp_sample));
      check("valid_at_done", int'(sample_valid), 1);
      check("overrun_at_done", int'(overrun), int'(vecs[i].exp_ovr));
      @(negedge clk);
      check("valid_after", int'(sample_valid), vecs[i].ready ? 0 : 1);
      check("overrun_pulse_end", int'(overrun), 0);
    end

    // Ready asserted only in the load cycle: old taken, new valid, no overrun.
    adc_word = 16'h0321;
    start_frame();
    check("seqA_period", t0 - prev_t0, Period);
    run_to(DoneLat - 1);
    check("seqA_sample_stable", int'(sample), 12'h555);
    check("seqA_valid_held", int'(sample_valid), 1);
    sample_ready = 1'b1;
    run_to(-1);
    sample_ready = 1'b0;
    check("seqA_done_lat", cyc - t0, DoneLat);
    check("seqA_sample", int'(sample), 12'h321);
    check("seqA_valid", int'(sample_valid), 1);
    check("seqA_overrun", int'(overrun), 0);
    @(negedge clk);
    check("seqA_valid_next", int'(sample_valid), 1);

    // Enable dropped after the 8th rise: frame completes, then no further frames.
    adc_word = 16'h0777;
    start_frame();
    run_to(8 * RisePitch);
    check("seqB_rises_at_drop", nrise, 8);
    enable = 1'b0;
    run_to(-1);
    check("seqB_done_lat", cyc - t0, DoneLat);
    check("seqB_sample", int'(sample), 12'h777);
    check("seqB_valid", int'(sample_valid), 1);
    check("seqB_overrun", int'(overrun), 1);
    watch_idle(250, 1'b1);
    check("seqB_no_frame", int'(hold_ok), 1);
    adc_word = 16'h0AAA;
    enable = 1'b1;
    en_cyc = cyc;
    start_frame();
    check("seqB_restart_lat", t0 - en_cyc, 1);

    // Reset after the 10th rise: outputs return to idle asynchronously.
    run_to(10 * RisePitch);
    check("seqC_rises_at_rst", nrise, 10);
    rst_n = 1'b0;
    #1;
    check("seqC_cs", int'(cs_adc), 1);
    check("seqC_sclk", int'(sclk_adc), 1);
    check("seqC_valid", int'(sample_valid), 0);
    check("seqC_sample", int'(sample), 0);
    check("seqC_busy", int'(busy), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_idle(250, 1'b0);
    check("seqC_quiet_after_rst", int'(hold_ok), 1);
    sample_ready = 1'b1;
    enable = 1'b1;
    start_frame();
    run_to(-1);
    check("seqC_done_lat", cyc - t0, DoneLat);
    check("seqC_sample", int'(sample), 12'hAAA);
    check("seqC_valid", int'(sample_valid), 1);

`ifdef TEST_PATTERN_EN
    test_mode = 1'b1;
    adc_word = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      start_frame();
      run_to(-1);
      check("ramp_sample", int'(sample), k);
      check("ramp_valid", int'(sample_valid), 1);
    end
    test_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
